sda_to_par: RTL and testbench
=============================

Name: sda_to_par

Overview:
- Receive end of the two-wire serial link whose transmit end converts a 4-bit parallel word into an SCL/SDA frame.
- Frame format: START (SDA falls while SCL high), NBITS data bits MSB first (SDA changes while SCL low, valid at SCL rising), STOP (SDA rises while SCL high).
- Block oversamples SCL/SDA on the system clock, decodes frames, and presents the word as binary plus a one-hot decode, with a valid pulse and frame-error flag.
- Sits beside the transmitter in the loopback testbench and in any design consuming the link.

Parameters:
- NBITS, 4, data bits per frame (1..8); one-hot width is 2**NBITS.

Ports:
- sclk  in  1  system clock; all logic on rising edge; must be >=4x SCL toggle rate.
- rst  in  1  synchronous, active-high reset.
- scl  in  1  serial clock from transmitter, asynchronous to sclk.
- sda  in  1  serial data from transmitter, asynchronous to sclk.
- data  out  NBITS  last correctly framed word.
- onehot  out  2**NBITS  onehot[data]=1, all other bits 0; all zero until first valid frame.
- valid  out  1  one-cycle pulse when data/onehot update.
- busy  out  1  high from START detection until frame ends (STOP or error).
- frame_err  out  1  one-cycle pulse on malformed frame.

Behaviour:
- Reset (rst=1 at a sclk edge): data=0, onehot=0, valid=0, busy=0, frame_err=0, state=IDLE, bit count=0. Synchronizer and history flops reset to 1 (idle bus high).
- Input conditioning: scl, sda each pass through a 2-flop synchronizer (scl_s, sda_s), plus one history flop (scl_d, sda_d).
- Event decode, combinational on synced signals:
  - scl_rise = scl_s & ~scl_d.
  - start_ev = scl_s & scl_d & sda_d & ~sda_s.
  - stop_ev = scl_s & scl_d & ~sda_d & sda_s.
  - SDA changes while SCL low, or in the same cycle SCL changes, are never START/STOP.
- Latency: raw transition first sampled at edge k; event decoded after edge k+1; state/outputs registered at edge k+2.
- State machine:
  - IDLE: start_ev -> RECV (busy=1, count=0, shift reg cleared). scl_rise and stop_ev ignored.
  - RECV: scl_rise -> shift sda_s in at LSB (first bit ends up MSB), count+1; when count reaches NBITS -> WAIT_STOP.
  - RECV: stop_ev with count<NBITS -> frame_err pulse, IDLE, busy=0; data/onehot unchanged.
  - RECV: start_ev (repeated start) -> frame_err pulse, stay RECV, count=0, shift reg cleared; busy stays 1.
  - WAIT_STOP: scl_rise ignored (trailing low bit before STOP is legal).
  - WAIT_STOP: stop_ev -> data<=shift reg, onehot<=1<<shift reg, valid pulse, busy=0, IDLE.
  - WAIT_STOP: start_ev -> frame_err pulse, RECV, count=0; received word discarded.
- valid and frame_err never assert in the same cycle; each is exactly one sclk cycle.
- Back-to-back frames: new START accepted in the cycle immediately after returning to IDLE.
- rst mid-frame aborts the frame with no valid/frame_err pulse; outputs return to reset values.
- No timeout: bus held indefinitely in any state keeps the current state.

Test Plan:
- Frame 4'b1011 (SCL period 8 sclk) -> one valid pulse, data=4'hB, onehot=16'h0800, busy low after STOP, frame_err never high.
- Frames 0..15 back-to-back, minimal gap -> 16 valid pulses in order; onehot=1<<n for each; no frame_err.
- START, 2 bits, repeated START, then full frame 4'h5 with STOP -> one frame_err pulse at second START; then valid with data=4'h5.
- START, 3 bits (1,1,0), STOP -> frame_err pulse, no valid; data/onehot keep previous value (e.g. 4'h5 / 16'h0020).
- rst=1 for one cycle after bit 2 of a frame -> next edge all outputs 0, busy=0; following clean frame 4'hA -> data=4'hA, onehot=16'h0400.
- SDA toggled while SCL low in IDLE, and SDA/SCL changed in same sclk cycle -> no busy, valid, or frame_err.

Source files
------------

// File: rtl/sda_to_par.sv
// sda_to_par: receive end of a two-wire SCL/SDA link.
// Oversamples SCL/SDA on sclk, decodes START / data bits / STOP frames and
// presents each correctly framed word as binary plus one-hot decode.
//
// Ports:
//   sclk      in   system clock, all logic on its rising edge (>= 4x SCL rate)
//   rst       in   synchronous active-high reset
//   scl, sda  in   serial clock / data from the transmitter (asynchronous)
//   data      out  last correctly framed word (NBITS)
//   onehot    out  1 << data, all zero until the first valid frame (2**NBITS)
//   valid     out  one-cycle pulse when data/onehot update
//   busy      out  high from START until the frame ends (STOP or error)
//   frame_err out  one-cycle pulse on a malformed frame
module sda_to_par #(
  parameter int NBITS = 4
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    scl,
  input  logic                    sda,
  output logic [NBITS-1:0]        data,
  output logic [(2**NBITS)-1:0]   onehot,
  output logic                    valid,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int CW  = $clog2(NBITS + 1);
  localparam int OHW = 2**NBITS;
  localparam logic [CW-1:0] LP_NBITS = CW'(NBITS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECV      = 2'd1,
    S_WAIT_STOP = 2'd2
  } state_t;

  // One-hot decode of a received word.
  function automatic logic [OHW-1:0] f_onehot(input logic [NBITS-1:0] word);
    logic [OHW-1:0] v;
    v       = {OHW{1'b0}};
    v[word] = 1'b1;
    return v;
  endfunction

  // Synchronizer (m, s) and history (d) flops; idle bus is high.
  logic r_scl_m, r_scl_s, r_scl_d;
  logic r_sda_m, r_sda_s, r_sda_d;

  state_t           r_state,  w_state;
  logic [CW-1:0]    r_count,  w_count;
  logic [NBITS-1:0] r_shift,  w_shift;
  logic [NBITS-1:0] r_data,   w_data;
  logic [OHW-1:0]   r_onehot, w_onehot;
  logic             r_valid,  w_valid;
  logic             r_busy,   w_busy;
  logic             r_err,    w_err;

  logic             w_scl_rise, w_start_ev, w_stop_ev;
  logic [NBITS-1:0] w_shift_in;
  logic [CW-1:0]    w_count_inc;

  // Events are only recognised when SCL was stable high across both samples,
  // so SDA moving while SCL is low or changing never forms START/STOP.
  assign w_scl_rise  = r_scl_s & ~r_scl_d;
  assign w_start_ev  = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
  assign w_stop_ev   = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;
  // Shift left, new bit at LSB; truncating cast keeps NBITS=1 legal.
  assign w_shift_in  = NBITS'({r_shift, r_sda_s});
  assign w_count_inc = r_count + {{(CW-1){1'b0}}, 1'b1};

  // Input synchronizers and history flops.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_scl_m <= 1'b1;
      r_scl_s <= 1'b1;
      r_scl_d <= 1'b1;
      r_sda_m <= 1'b1;
      r_sda_s <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_m <= scl;
      r_scl_s <= r_scl_m;
      r_scl_d <= r_scl_s;
      r_sda_m <= sda;
      r_sda_s <= r_sda_m;
      r_sda_d <= r_sda_s;
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= {CW{1'b0}};
      r_shift  <= {NBITS{1'b0}};
      r_data   <= {NBITS{1'b0}};
      r_onehot <= {OHW{1'b0}};
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_shift  <= w_shift;
      r_data   <= w_data;
      r_onehot <= w_onehot;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
      r_err    <= w_err;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_shift  = r_shift;
    w_data   = r_data;
    w_onehot = r_onehot;
    w_valid  = 1'b0;
    w_busy   = r_busy;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ev) begin
          w_state = S_RECV;
          w_busy  = 1'b1;
          w_count = {CW{1'b0}};
          w_shift = {NBITS{1'b0}};
        end else begin
          w_state = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_start_ev) begin
          // Repeated start: restart the word, stay busy.
          w_err   = 1'b1;
          w_count = {CW{1'b0}};
          w_shift = {NBITS{1'b0}};
        end else if (w_stop_ev) begin
          w_err   = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else if (w_scl_rise) begin
          w_shift = w_shift_in;
          w_count = w_count_inc;
          if (w_count_inc == LP_NBITS) begin
            w_state = S_WAIT_STOP;
          end else begin
            w_state = S_RECV;
          end
        end else begin
          w_state = S_RECV;
        end
      end
      S_WAIT_STOP: begin
        // An SCL rise here is the trailing low bit before STOP; ignored.
        if (w_stop_ev) begin
          w_data   = r_shift;
          w_onehot = f_onehot(r_shift);
          w_valid  = 1'b1;
          w_busy   = 1'b0;
          w_state  = S_IDLE;
        end else if (w_start_ev) begin
          w_err   = 1'b1;
          w_state = S_RECV;
          w_count = {CW{1'b0}};
          w_shift = {NBITS{1'b0}};
        end else begin
          w_state = S_WAIT_STOP;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_count = {CW{1'b0}};
      end
    endcase
  end

  assign data      = r_data;
  assign onehot    = r_onehot;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_err = r_err;

endmodule

// File: tb/tb_sda_to_par.sv
// Self-checking bench for sda_to_par (NBITS=4). A scoreboard queue holds the
// words expected on each valid pulse; scenario tasks check busy, data,
// onehot and the pulse counts.
module tb_sda_to_par;

  logic        sclk = 1'b0;
  logic        rst  = 1'b1;
  logic        scl  = 1'b1;
  logic        sda  = 1'b1;
  logic [3:0]  data;
  logic [15:0] onehot;
  logic        valid;
  logic        busy;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  logic [3:0] exp_q[$];

  sda_to_par #(.NBITS(4)) dut (
    .sclk(sclk), .rst(rst), .scl(scl), .sda(sda),
    .data(data), .onehot(onehot), .valid(valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 sclk = ~sclk;

  // Monitor: pops the scoreboard on each valid pulse, checks pulse shape.
  always @(negedge sclk) begin
    logic [3:0]  e;
    logic [15:0] oh;
    if (valid === 1'b1) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_valid: data=%h, no word expected", data);
      end else begin
        e  = exp_q.pop_front();
        oh = 16'h0001 << e;
        if (data !== e || onehot !== oh) begin
          n_errors++;
          $display("FAIL sb_word: data=%h onehot=%h, expected data=%h onehot=%h", data, onehot, e, oh);
        end
      end
    end
    if (frame_err === 1'b1) n_err++;
    if (valid === 1'b1 || frame_err === 1'b1) begin
      n_checks++;
      if ((valid && frame_err) || (valid && prev_valid) || (frame_err && prev_err)) begin
        n_errors++;
        $display("FAIL pulse_shape: valid=%b err=%b prev_valid=%b prev_err=%b, expected single non-overlapping pulses",
                 valid, frame_err, prev_valid, prev_err);
      end
    end
    prev_valid = valid;
    prev_err   = frame_err;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // SCL period 8 sclk: low 4, high 4.
  task automatic send_start();
    scl = 1'b1; sda = 1'b0; cyc(4);
    scl = 1'b0; cyc(2);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    cyc(2);
    scl = 1'b1; cyc(4);
    scl = 1'b0; cyc(2);
  endtask

  // Trailing low bit, then SDA rises while SCL high.
  task automatic send_stop(input int hold);
    sda = 1'b0; cyc(2);
    scl = 1'b1; cyc(4);
    sda = 1'b1; cyc(hold);
  endtask

  task automatic send_rstart();
    sda = 1'b1; cyc(2);
    scl = 1'b1; cyc(4);
    sda = 1'b0; cyc(4);
    scl = 1'b0; cyc(2);
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(3);
    n_checks++;
    if (data !== 4'h0 || onehot !== 16'h0 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: data=%h onehot=%h valid=%b busy=%b err=%b, expected all 0",
               data, onehot, valid, busy, frame_err);
    end
    rst = 1'b0; cyc(3);
  endtask

  task automatic test_single();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL single_busy_start: busy=%b, expected 1", busy);
    end
    send_word(4'b1011);
    exp_q.push_back(4'hB);
    send_stop(4);
    n_checks++;
    if (busy !== 1'b0 || data !== 4'hB || onehot !== 16'h0800 || n_valid - v0 != 1 || n_err != e0) begin
      n_errors++;
      $display("FAIL single_frame: busy=%b data=%h onehot=%h valids=%0d errs=%0d, expected 0 b 0800 1 0",
               busy, data, onehot, n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    for (int n = 0; n < 16; n++) begin
      send_start();
      send_word(4'(n));
      exp_q.push_back(4'(n));
      send_stop(2);
    end
    cyc(4);
    n_checks++;
    if (n_valid - v0 != 16 || n_err != e0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_counts: valids=%0d errs=%0d pending=%0d, expected 16 0 0",
               n_valid - v0, n_err - e0, exp_q.size());
    end
  endtask

  task automatic test_repeated_start();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_rstart();
    n_checks++;
    if (n_err - e0 != 1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rstart_err: errs=%0d busy=%b, expected 1 1", n_err - e0, busy);
    end
    send_word(4'h5);
    exp_q.push_back(4'h5);
    send_stop(4);
    n_checks++;
    if (n_valid - v0 != 1 || n_err - e0 != 1 || data !== 4'h5 || onehot !== 16'h0020 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rstart_frame: valids=%0d errs=%0d data=%h onehot=%h busy=%b, expected 1 1 5 0020 0",
               n_valid - v0, n_err - e0, data, onehot, busy);
    end
  endtask

  task automatic test_short_frame();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_stop(4);  // third bit (0) is clocked by the stop's SCL rise
    n_checks++;
    if (n_valid != v0 || n_err - e0 != 1 || data !== 4'h5 || onehot !== 16'h0020 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL short_frame: valids=%0d errs=%0d data=%h onehot=%h busy=%b, expected 0 1 5 0020 0",
               n_valid - v0, n_err - e0, data, onehot, busy);
    end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1; cyc(1);
    n_checks++;
    if (data !== 4'h0 || onehot !== 16'h0 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_state: data=%h onehot=%h valid=%b busy=%b err=%b, expected all 0",
               data, onehot, valid, busy, frame_err);
    end
    rst = 1'b0;
    sda = 1'b1; cyc(2);
    scl = 1'b1; cyc(4);
    send_start();
    send_word(4'hA);
    exp_q.push_back(4'hA);
    send_stop(4);
    n_checks++;
    if (n_valid - v0 != 1 || n_err != e0 || data !== 4'hA || onehot !== 16'h0400) begin
      n_errors++;
      $display("FAIL midrst_frame: valids=%0d errs=%0d data=%h onehot=%h, expected 1 0 a 0400",
               n_valid - v0, n_err - e0, data, onehot);
    end
  endtask

  task automatic test_glitch();
    // {scl, sda, hold cycles}: SDA toggles with SCL low, then simultaneous edges.
    logic [1:0] lv [0:11];
    int         hd [0:11];
    int v0, e0;
    lv = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11,
           2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11};
    hd = '{3, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 2};
    v0 = n_valid; e0 = n_err;
    for (int s = 0; s < 12; s++) begin
      scl = lv[s][1];
      sda = lv[s][0];
      for (int c = 0; c < hd[s]; c++) begin
        cyc(1);
        n_checks++;
        if (busy !== 1'b0) begin
          n_errors++;
          $display("FAIL glitch_busy: step=%0d busy=%b, expected 0", s, busy);
        end
      end
    end
    n_checks++;
    if (n_valid != v0 || n_err != e0) begin
      n_errors++;
      $display("FAIL glitch_pulses: valids=%0d errs=%0d, expected 0 0", n_valid - v0, n_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_repeated_start();
    test_short_frame();
    test_reset_mid();
    test_glitch();
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
